// File: rtl/mem_responder_pkg.sv
// Shared types for the load/store memory responder: request/response payloads and defaults.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_responder_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] mtrans;

   // One load/store request as issued by the mem exec unit.
   typedef struct packed {
      addr_t       a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] d;
   } mem_req_t;

   localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the mem exec unit and the memory responder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both channels; master drives requests, slave drives responses.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic     req_valid;
   logic     req_ready;
   mem_req_t req;

   logic     resp_valid;
   logic     resp_ready;
   mtrans    resp_data;

   modport master (
      output req_valid, req, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req, resp_ready,
      output req_ready, resp_valid, resp_data
   );

endinterface

// File: rtl/mem_responder_sync_fifo.sv
// Generic synchronous FIFO (sync_fifo): WIDTH-bit entries, DEPTH entries, show-ahead dout.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, rst (async, active-high), push/din, pop/dout, full, empty, count.
module mem_responder_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = storage[rd_ptr];
   // A pop frees the slot this cycle, so a push into a full FIFO is fine alongside it.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         storage[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed SRAM responder for the load/store port: one in-order response per request.
// Latency: LATENCY cycles from request fire to response valid (empty buffer, ready high).
// Backpressure: req_ready drops once QUEUE_DEPTH requests are outstanding; pipeline never stalls.
// Ports: clk, rst (async, active-high), bus (slave side of mem_responder_if: req and resp channels).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE        = MEM_BASE_DEFAULT,
   parameter int          LATENCY     = 2,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);

   localparam int          IW    = $clog2(DEPTH_WORDS);
   localparam int          CW    = $clog2(QUEUE_DEPTH + 1);
   // 33-bit limit so a window ending at 4 GiB does not wrap.
   localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH_WORDS);

   mem_req_t      req;
   logic          req_fire;
   logic          resp_fire;
   logic [CW-1:0] outstanding;

   logic [31:0]   offset;
   logic          in_range;
   logic [IW-1:0] idx;
   logic [31:0]   mem [DEPTH_WORDS];
   mtrans         rd_word;

   logic [LATENCY-1:0] pipe_vld;
   mtrans              pipe_dat [LATENCY];
   logic               out_vld;
   mtrans              out_dat;

   logic          fifo_push;
   logic          fifo_pop;
   mtrans         fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_ok;

   assign req = bus.req;

   // Ready depends only on the registered count, never on resp_ready.
   assign bus.req_ready = (outstanding < CW'(QUEUE_DEPTH));
   assign req_fire      = bus.req_valid && bus.req_ready;

   // Address decode; BASE is aligned to the window size so the index is a plain bit slice.
   assign offset   = req.a - BASE;
   assign in_range = ({1'b0, req.a} >= {1'b0, BASE}) && ({1'b0, req.a} < LIMIT);
   assign idx      = offset[IW+1:2];

   // Writes commit at the fire edge, so a read one cycle later already sees them.
   always_ff @(posedge clk) begin
      if (req_fire && req.we && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (req.be[i]) begin
               mem[idx][8*i +: 8] <= req.d[8*i +: 8];
            end
         end
      end
   end

   // Writes and out-of-range reads answer with zero.
   assign rd_word = (in_range && !req.we) ? mem[idx] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= req_fire;
         pipe_dat[0] <= rd_word;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

   assign out_vld = pipe_vld[LATENCY-1];
   assign out_dat = pipe_dat[LATENCY-1];

   // Empty buffer: pipeline output goes straight to the port, and is parked in the
   // FIFO only if the consumer is not ready, so the held data stays the same word.
   assign fifo_push = out_vld && !(fifo_empty && bus.resp_ready);
   assign fifo_pop  = !fifo_empty && bus.resp_ready;

   mem_responder_sync_fifo #(
      .WIDTH (32),
      .DEPTH (QUEUE_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (out_dat),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.resp_valid = fifo_empty ? out_vld : 1'b1;
   assign bus.resp_data  = fifo_empty ? out_dat : fifo_dout;
   assign resp_fire      = bus.resp_valid && bus.resp_ready;

   // Counts pipeline plus buffer occupancy; bounds the FIFO so it cannot overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({req_fire, resp_fire})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign unused_ok = ^{offset[31:IW+2], offset[1:0], fifo_full, fifo_count};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vectors plus a random stream against a queue model.
// Latency: n/a.
// Backpressure: the bench drives resp_ready directly (held, released or randomised).
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int          LAT  = 2;
   localparam int          QD   = 4;
   localparam int          DW   = 1024;
   localparam logic [31:0] BASE = 32'h8000_0000;

   typedef struct {
      logic [31:0] data;
      bit          known;
      int          fire_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_responder_if bus();

   mem_responder #(
      .DEPTH_WORDS (DW),
      .BASE        (BASE),
      .LATENCY     (LAT),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_fire   = 0;
   int n_resp   = 0;

   exp_t        exp_q[$];
   logic [31:0] mdl_mem [int unsigned];
   logic [31:0] rlog_dat[$];
   int          rlog_cyc[$];
   bit          rand_rdy = 1'b0;

   // Monitor scratch
   bit          prev_hold = 1'b0;
   logic [31:0] prev_data;
   bit          mon_due;
   mem_req_t    mon_r;
   exp_t        mon_e;
   logic [31:0] mon_w;
   int unsigned mon_ix;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      longint unsigned la, lb;
      la = a;
      lb = BASE;
      return (la >= lb) && (la < lb + 4 * DW);
   endfunction

   // Reference model: memory as an associative array, responses as an in-order queue,
   // each response due exactly LAT cycles after its fire.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_hold = 1'b0;
         chk("valid_in_reset", bus.resp_valid, 0);
      end else begin
         mon_due = (exp_q.size() > 0) && (cyc >= exp_q[0].fire_cyc + LAT);
         chk("resp_valid", bus.resp_valid, mon_due);
         chk("req_ready", bus.req_ready, exp_q.size() < QD);
         chk("outstanding_max", exp_q.size() <= QD, 1);
         if (bus.resp_valid) begin
            if (prev_hold) chk("resp_stable", bus.resp_data, prev_data);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: got %h with nothing outstanding", bus.resp_data);
            end else if (exp_q[0].known) begin
               chk("resp_data", bus.resp_data, exp_q[0].data);
            end
         end
         prev_hold = bus.resp_valid && !bus.resp_ready;
         prev_data = bus.resp_data;
         if (bus.resp_valid && bus.resp_ready) begin
            n_resp++;
            rlog_dat.push_back(bus.resp_data);
            rlog_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (bus.req_valid && bus.req_ready) begin
            n_fire++;
            mon_r = bus.req;
            mon_e.data     = 32'h0;
            mon_e.known    = 1'b1;
            mon_e.fire_cyc = cyc;
            if (in_rng(mon_r.a)) begin
               mon_ix = (mon_r.a - BASE) >> 2;
               if (mon_r.we) begin
                  mon_w = mdl_mem.exists(mon_ix) ? mdl_mem[mon_ix] : 32'hx;
                  for (int i = 0; i < 4; i++)
                     if (mon_r.be[i]) mon_w[8*i +: 8] = mon_r.d[8*i +: 8];
                  if (!$isunknown(mon_w)) mdl_mem[mon_ix] = mon_w;
               end else if (mdl_mem.exists(mon_ix)) begin
                  mon_e.data = mdl_mem[mon_ix];
               end else begin
                  mon_e.known = 1'b0;
               end
            end
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) bus.resp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] d, output int fc);
      bit fired = 1'b0;
      fc = -1;
      bus.req_valid = 1'b1;
      bus.req.a  = a;
      bus.req.we = we;
      bus.req.be = be;
      bus.req.d  = d;
      for (int n = 0; n < 100 && !fired; n++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            fired = 1'b1;
            fc = cyc;
         end
         tick();
      end
      bus.req_valid = 1'b0;
      if (!fired) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: request %h never accepted", a);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick();
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
      end
   endtask

   task automatic clear_log();
      rlog_dat.delete();
      rlog_cyc.delete();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int fc, fc2, k;
      logic [31:0] a;
      bus.req_valid  = 1'b0;
      bus.req        = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      tick();

      // Known contents for words 0..15
      for (int i = 0; i < 16; i++) send(BASE + 32'(4 * i), 1'b1, 4'hF, 32'h1000_0000 + 32'(i), fc);
      drain();

      // Full write then read back; read answers exactly LAT cycles after fire
      clear_log();
      send(32'h8000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, fc);
      send(32'h8000_0010, 1'b0, 4'b0000, 32'h0, fc2);
      drain();
      chk("t1_count", rlog_dat.size(), 2);
      chk("t1_wr_resp", rlog_dat[0], 32'h0);
      chk("t1_rd_resp", rlog_dat[1], 32'hDEAD_BEEF);
      chk("t1_latency", rlog_cyc[1] - fc2, 2);

      // Byte-lane merge, then a be=0 write leaves the word alone
      clear_log();
      send(32'h8000_0010, 1'b1, 4'b0100, 32'h00AA_0000, fc);
      send(32'h8000_0010, 1'b0, 4'b0000, 32'h0, fc);
      send(32'h8000_0010, 1'b1, 4'b0000, 32'hFFFF_FFFF, fc);
      send(32'h8000_0010, 1'b0, 4'b1111, 32'h0, fc);
      drain();
      chk("t2_merge", rlog_dat[1], 32'hDEAA_BEEF);
      chk("t2_be0", rlog_dat[3], 32'hDEAA_BEEF);

      // Backpressure: hold ready low, stream reads of words 8..11
      clear_log();
      bus.resp_ready = 1'b0;
      k = 0;
      bus.req_valid = 1'b1;
      bus.req.we = 1'b0;
      bus.req.be = 4'hF;
      bus.req.a  = BASE + 32'd32;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.req_ready) k++;
         tick();
         bus.req.a = BASE + 32'd32 + 32'(4 * k);
      end
      bus.req_valid = 1'b0;
      chk("t3_accepted", k, 4);
      @(negedge clk);
      chk("t3_req_ready_full", bus.req_ready, 0);
      chk("t3_head_valid", bus.resp_valid, 1);
      chk("t3_head_data", bus.resp_data, 32'h1000_0008);
      tick();
      bus.resp_ready = 1'b1;
      drain();
      chk("t3_count", rlog_dat.size(), 4);
      for (int i = 0; i < 4; i++) chk("t3_order", rlog_dat[i], 32'h1000_0008 + 32'(i));
      chk("t3_back_to_back", rlog_cyc[3] - rlog_cyc[0], 3);
      @(negedge clk);
      chk("t3_ready_back", bus.req_ready, 1);
      tick();

      // Out-of-range accesses
      clear_log();
      send(32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0, fc);
      send(32'h8000_1000, 1'b0, 4'hF, 32'h0, fc);
      send(32'h8000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, fc);
      send(32'h8000_0000, 1'b0, 4'hF, 32'h0, fc);
      drain();
      chk("t4_below", rlog_dat[0], 32'h0);
      chk("t4_above", rlog_dat[1], 32'h0);
      chk("t4_oor_wr_resp", rlog_dat[2], 32'h0);
      chk("t4_word0_intact", rlog_dat[3], 32'h1000_0000);

      // Random stream with random consumer readiness
      rand_rdy = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 3) == 0) tick();
         case ($urandom_range(0, 13))
            0:       a = BASE - 32'd4;
            1:       a = BASE + 32'(4 * DW);
            2:       a = 32'hFFFF_FFFC;
            3:       a = 32'h0000_0000;
            default: a = BASE + 32'(4 * $urandom_range(0, 15));
         endcase
         a = a | 32'($urandom_range(0, 3));
         send(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, fc);
      end
      rand_rdy = 1'b0;
      bus.resp_ready = 1'b1;
      drain();
      chk("t5_no_lost_or_dup", n_resp, n_fire);

      // Reset with three reads in flight
      clear_log();
      send(32'h8000_0014, 1'b1, 4'hF, 32'hCAFE_F00D, fc);
      drain();
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h8000_0014, 1'b0, 4'hF, 32'h0, fc);
      @(negedge clk);
      chk("t6_valid_before_rst", bus.resp_valid, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", bus.resp_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("t6_req_ready", bus.req_ready, 1);
      chk("t6_resp_valid", bus.resp_valid, 0);
      clear_log();
      repeat (5) tick();
      chk("t6_no_stale", rlog_dat.size(), 0);
      send(32'h8000_0014, 1'b0, 4'hF, 32'h0, fc);
      drain();
      chk("t6_write_kept", rlog_dat[0], 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
